iob_cache_be_mem_model: RTL and testbench

- Parametrised backend memory model for cache simulation: a native IOb slave with byte-enabled writes.
- Read latency is configurable and fully pipelined.
- Ready backpressure follows a deterministic periodic stall pattern.
- Read and write access counters are exposed.
- Connects to the cache backend port (be_*). Lets the cache's ready/rvalid handling be exercised beyond the fixed ready=1, one-cycle-rvalid case.

---
 rtl/iob_cache_be_mem_model.sv | 91 +++++++++
 tb/tb_iob_cache_be_mem_model.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_be_mem_model.sv
// Backend memory model for cache simulation: IOb slave with byte-enabled writes,
// a pipelined read latency of RD_LAT cycles and a periodic ready-stall pattern.
module iob_cache_be_mem_model #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 24,
  parameter int NBYTES       = DATA_W / 8,
  parameter int NBYTES_W     = $clog2(NBYTES),
  parameter int RD_LAT       = 1,
  parameter int STALL_PERIOD = 0,
  parameter int STALL_LEN    = 0,
  parameter int CNT_W        = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cke_i,
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [NBYTES-1:0] iob_wstrb_i,
  output logic [DATA_W-1:0] iob_rdata_o,
  output logic              iob_rvalid_o,
  output logic              iob_ready_o,
  output logic [CNT_W-1:0]  rd_cnt_o,
  output logic [CNT_W-1:0]  wr_cnt_o
);

  localparam int WORDS = 2 ** (ADDR_W - NBYTES_W);
  localparam int PH_W  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);
  localparam logic [PH_W-1:0] PH_LEN  = PH_W'(STALL_LEN);

  if (RD_LAT < 1 || RD_LAT > 16) begin : g_bad_lat
    $error("iob_cache_be_mem_model: RD_LAT must be within 1..16");
  end
  if (STALL_PERIOD > 0 && STALL_LEN >= STALL_PERIOD) begin : g_bad_stall
    $error("iob_cache_be_mem_model: STALL_LEN must be below STALL_PERIOD");
  end

  logic [DATA_W-1:0]          mem [WORDS];
  logic [ADDR_W-NBYTES_W-1:0] idx;
  logic                       acc;
  logic                       wr;
  logic                       rd;
  logic [PH_W-1:0]            phase;
  logic [RD_LAT-1:0]          p_vld;
  logic [DATA_W-1:0]          p_dat [RD_LAT];
  logic                       unused_addr_lsb;

  assign idx             = iob_addr_i[ADDR_W-1:NBYTES_W];
  assign unused_addr_lsb = ^iob_addr_i[NBYTES_W-1:0];
  assign iob_ready_o     = (STALL_PERIOD == 0) || (phase >= PH_LEN);
  assign acc             = iob_valid_i & iob_ready_o & cke_i;
  assign wr              = acc & (|iob_wstrb_i);
  assign rd              = acc & ~(|iob_wstrb_i);

  // Array contents are deliberately not reset, so it lives in its own block.
  always_ff @(posedge clk_i) begin
    if (wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (iob_wstrb_i[i]) mem[idx][i*8 +: 8] <= iob_wdata_i[i*8 +: 8];
      end
    end
  end

  // Data stages only load when a valid word arrives, so the last stage keeps
  // the previous response on the bus while rvalid is low.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      p_vld    <= '0;
      for (int i = 0; i < RD_LAT; i++) p_dat[i] <= '0;
      phase    <= '0;
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else if (cke_i) begin
      p_vld[0] <= rd;
      if (rd) p_dat[0] <= mem[idx];
      for (int i = 1; i < RD_LAT; i++) begin
        p_vld[i] <= p_vld[i-1];
        if (p_vld[i-1]) p_dat[i] <= p_dat[i-1];
      end
      if (STALL_PERIOD == 0 || phase == PH_LAST) phase <= '0;
      else phase <= phase + 1'b1;
      if (rd) rd_cnt_o <= rd_cnt_o + 1'b1;
      if (wr) wr_cnt_o <= wr_cnt_o + 1'b1;
    end
  end

  assign iob_rvalid_o = p_vld[RD_LAT-1];
  assign iob_rdata_o  = p_dat[RD_LAT-1];

endmodule

// File: tb/tb_iob_cache_be_mem_model.sv
// Directed bench: four model instances share one request bus; each scenario
// checks the instance whose parameters it targets.
module tb_iob_cache_be_mem_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        valid = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic [31:0] d_rdata, l4_rdata, s_rdata, l2_rdata;
  logic        d_rvalid, l4_rvalid, s_rvalid, l2_rvalid;
  logic        d_ready, l4_ready, s_ready, l2_ready;
  logic [31:0] d_rd, d_wr, l4_rd, l4_wr, s_rd, s_wr, l2_rd, l2_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_cache_be_mem_model u_def (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(d_rdata), .iob_rvalid_o(d_rvalid),
    .iob_ready_o(d_ready), .rd_cnt_o(d_rd), .wr_cnt_o(d_wr));

  iob_cache_be_mem_model #(.ADDR_W(12), .RD_LAT(4)) u_lat4 (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr[11:0]),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(l4_rdata), .iob_rvalid_o(l4_rvalid),
    .iob_ready_o(l4_ready), .rd_cnt_o(l4_rd), .wr_cnt_o(l4_wr));

  iob_cache_be_mem_model #(.ADDR_W(12), .STALL_PERIOD(4), .STALL_LEN(2)) u_stall (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr[11:0]),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(s_rdata), .iob_rvalid_o(s_rvalid),
    .iob_ready_o(s_ready), .rd_cnt_o(s_rd), .wr_cnt_o(s_wr));

  iob_cache_be_mem_model #(.ADDR_W(12), .RD_LAT(2)) u_lat2 (
    .clk_i(clk), .arst_i(rst), .cke_i(cke), .iob_valid_i(valid), .iob_addr_i(addr[11:0]),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(l2_rdata), .iob_rvalid_o(l2_rvalid),
    .iob_ready_o(l2_ready), .rd_cnt_o(l2_rd), .wr_cnt_o(l2_wr));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and samples both live 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic req(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
  endtask

  task automatic idle();
    valid = 1'b0; wstrb = '0;
  endtask

  initial begin
    int seen;
    #1;
    // Reset values while reset is held.
    chk("rst_ready_def", d_ready, 1);
    chk("rst_ready_stall", s_ready, 0);
    chk("rst_rvalid", d_rvalid, 0);
    chk("rst_rdata", d_rdata, 0);
    chk("rst_rd_cnt", d_rd, 0);
    chk("rst_wr_cnt", d_wr, 0);
    tick();
    rst = 1'b0;

    // Full-word write then read, RD_LAT=1.
    req(24'h10, 32'hDEADBEEF, 4'hF); tick();
    chk("wr_no_rvalid", d_rvalid, 0);
    req(24'h10, 32'h0, 4'h0); tick();
    chk("rd1_rvalid", d_rvalid, 1);
    chk("rd1_rdata", d_rdata, 32'hDEADBEEF);
    idle(); tick();
    chk("rd1_pulse_end", d_rvalid, 0);
    chk("rd1_rdata_hold", d_rdata, 32'hDEADBEEF);
    chk("def_wr_cnt", d_wr, 1);
    chk("def_rd_cnt", d_rd, 1);

    // Byte strobes 0x5 update bytes 0 and 2 only.
    req(24'h20, 32'h11223344, 4'hF); tick();
    req(24'h20, 32'hAABBCCDD, 4'h5); tick();
    req(24'h20, 32'h0, 4'h0); tick();
    chk("strb_rvalid", d_rvalid, 1);
    chk("strb_rdata", d_rdata, 32'h11BB33DD);
    idle(); tick();

    // RD_LAT=4 back-to-back reads.
    do_reset();
    req(24'h0, 32'd1, 4'hF); tick();
    req(24'h4, 32'd2, 4'hF); tick();
    req(24'h8, 32'd3, 4'hF); tick();
    req(24'h0, 32'h0, 4'h0); tick();
    chk("lat4_t1", l4_rvalid, 0);
    req(24'h4, 32'h0, 4'h0); tick();
    req(24'h8, 32'h0, 4'h0); tick();
    chk("lat4_t3", l4_rvalid, 0);
    idle(); tick();
    chk("lat4_v1", l4_rvalid, 1);
    chk("lat4_d1", l4_rdata, 1);
    tick();
    chk("lat4_v2", l4_rvalid, 1);
    chk("lat4_d2", l4_rdata, 2);
    tick();
    chk("lat4_v3", l4_rvalid, 1);
    chk("lat4_d3", l4_rdata, 3);
    tick();
    chk("lat4_end", l4_rvalid, 0);
    chk("lat4_rd_cnt", l4_rd, 3);

    // Stall pattern 0,0,1,1 with valid held for 16 cycles.
    do_reset();
    req(24'h0, 32'h0, 4'h0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("stall_ready_%0d", k), s_ready, ((k % 4) >= 2) ? 1 : 0);
      tick();
    end
    idle();
    chk("stall_rd_cnt", s_rd, 8);
    chk("stall_wr_cnt", s_wr, 0);

    // Reset with three reads in flight.
    do_reset();
    req(24'h0, 32'h0, 4'h0); tick();
    req(24'h4, 32'h0, 4'h0); tick();
    req(24'h8, 32'h0, 4'h0); tick();
    idle();
    chk("inflight_cnt", l4_rd, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd_cnt", l4_rd, 0);
    chk("arst_rvalid", l4_rvalid, 0);
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (l4_rvalid) seen++;
      tick();
    end
    chk("arst_no_rvalid", seen, 0);
    chk("arst_rd_cnt_after", l4_rd, 0);
    chk("arst_wr_cnt_after", l4_wr, 0);

    // Clock-enable hold for 5 cycles during an RD_LAT=2 read.
    do_reset();
    req(24'h40, 32'hCAFEF00D, 4'hF); tick();
    req(24'h40, 32'h0, 4'h0); tick();
    chk("cke_rd_cnt", l2_rd, 1);
    chk("cke_pre_ready", s_ready, 1);
    cke = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("cke_hold_rvalid_%0d", k), l2_rvalid, 0);
      chk($sformatf("cke_hold_rd_cnt_%0d", k), l2_rd, 1);
      chk($sformatf("cke_hold_phase_%0d", k), s_ready, 1);
    end
    idle();
    cke = 1'b1;
    tick();
    chk("cke_rvalid", l2_rvalid, 1);
    chk("cke_rdata", l2_rdata, 32'hCAFEF00D);
    chk("cke_wr_cnt", l2_wr, 1);
    cke = 1'b0;
    tick(); tick();
    chk("cke_pulse_held", l2_rvalid, 1);
    cke = 1'b1;
    tick();
    chk("cke_pulse_end", l2_rvalid, 0);
    chk("cke_rd_cnt_end", l2_rd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
